// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- control FSM for the stopwatch counter datapath.
//
// Conditions the raw board buttons (two-flop synchroniser, debounce, one-cycle
// press pulse) and sequences the Counter through CLEARED / RUNNING / PAUSED.
//
// Ports:
//   clk              in   system clock (100 MHz)
//   reset            in   synchronous, active-high reset
//   btn_start_stop   in   raw button, start/pause toggle
//   btn_clear        in   raw button, zero the counter (only honoured while PAUSED)
//   btn_lap          in   raw button, lap hold (only used with LAP_HOLD_EN)
//   time_reading     in   {tens,ones} BCD from Counter
//   init_regs        out  to Counter, high while CLEARED
//   count_enabled    out  to Counter, high while RUNNING
//   running          out  status LED, same as count_enabled
//   display_reading  out  {tens,ones} BCD to the 7-segment driver
//
// Build option: define LAP_HOLD_EN to build the lap-hold display freeze.
// Without it btn_lap is ignored and display_reading is time_reading.
//
// Parameter DB_CYCLES (>= 2): consecutive stable cycles before a debounced
// level changes.

// Per-button conditioning: sync -> debounce -> rising-edge pulse.
module stopwatch_btn #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level; any agreement (a glitch ending) restarts it from zero.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = db_q & ~db_dly_q;
endmodule

module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [7:0] time_reading,
  output logic       init_regs,
  output logic       count_enabled,
  output logic       running,
  output logic [7:0] display_reading
);
  // state    | meaning
  // CLEARED  | counter held at zero (init_regs high)
  // RUNNING  | counter advancing (count_enabled high)
  // PAUSED   | counter frozen, may be resumed or cleared
  typedef enum logic [1:0] {
    ST_CLEARED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   start_press, clear_press;

  stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_start_stop),
    .press_o (start_press)
  );

  stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_clear),
    .press_o (clear_press)
  );

  // Clear is only meaningful while PAUSED, where it beats a simultaneous start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEARED: if (start_press) state_d = ST_RUNNING;
      ST_RUNNING: if (start_press) state_d = ST_PAUSED;
      ST_PAUSED: begin
        if (clear_press)      state_d = ST_CLEARED;
        else if (start_press) state_d = ST_RUNNING;
      end
      default: state_d = ST_CLEARED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_CLEARED;
    else       state_q <= state_d;
  end

  assign init_regs     = (state_q == ST_CLEARED);
  assign count_enabled = (state_q == ST_RUNNING);
  assign running       = count_enabled;

`ifdef LAP_HOLD_EN
  logic       lap_press;
  logic       hold_q, hold_d;
  logic [7:0] lap_q, lap_d;

  stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_lap (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_lap),
    .press_o (lap_press)
  );

  // Going to CLEARED always drops the hold, even if a lap press lands on the
  // same cycle.
  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if (state_d == ST_CLEARED) begin
      hold_d = 1'b0;
    end else if (lap_press) begin
      if (hold_q) begin
        if (state_q != ST_CLEARED) hold_d = 1'b0;
      end else if (state_q == ST_RUNNING) begin
        hold_d = 1'b1;
        lap_d  = time_reading;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
      lap_q  <= 8'h00;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end

  assign display_reading = hold_q ? lap_q : time_reading;
`else
  logic unused_btn_lap;
  assign unused_btn_lap  = btn_lap;
  assign display_reading = time_reading;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start_stop, btn_clear, btn_lap;
  logic [7:0] time_reading;
  logic       init_regs, count_enabled, running;
  logic [7:0] display_reading;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_start_stop  (btn_start_stop),
    .btn_clear       (btn_clear),
    .btn_lap         (btn_lap),
    .time_reading    (time_reading),
    .init_regs       (init_regs),
    .count_enabled   (count_enabled),
    .running         (running),
    .display_reading (display_reading)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       init;
    logic       run;
    logic [7:0] disp;
  } exp_t;

  typedef struct {
    string nm;
    logic  s;
    logic  c;
    int    len;
    logic  init;
    logic  run;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[17];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic init, input logic run,
                          input logic [7:0] disp);
    exp_t e;
    e.nm = nm; e.init = init; e.run = run; e.disp = disp;
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
    end else begin
      e = sb_q.pop_front();
      cmp({e.nm, ".init_regs"}, {7'd0, init_regs}, {7'd0, e.init});
      cmp({e.nm, ".count_enabled"}, {7'd0, count_enabled}, {7'd0, e.run});
      cmp({e.nm, ".running"}, {7'd0, running}, {7'd0, e.run});
      cmp({e.nm, ".exclusive"}, {7'd0, init_regs & count_enabled}, 8'd0);
      cmp({e.nm, ".display"}, display_reading, e.disp);
    end
  endtask

  // Hold one or both buttons for len cycles, then release and let the
  // release debounce settle before the next press.
  task automatic press(input logic s, input logic c, input logic l, input int len);
    btn_start_stop = s; btn_clear = c; btn_lap = l;
    tick(len);
    btn_start_stop = 0; btn_clear = 0; btn_lap = 0;
    tick(10);
  endtask

  task automatic expect_now(input string nm, input logic init, input logic run);
    push_exp(nm, init, run, time_reading);
    check_sb();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"glitch1",        1, 0, 1, 1, 0};
    vecs[1]  = '{"glitch2",        1, 0, 2, 1, 0};
    vecs[2]  = '{"glitch3",        1, 0, 3, 1, 0};
    vecs[3]  = '{"clr_in_cleared", 0, 1, 6, 1, 0};
    vecs[4]  = '{"start",          1, 0, 6, 0, 1};
    vecs[5]  = '{"clr_in_running", 0, 1, 6, 0, 1};
    vecs[6]  = '{"glitch_running", 1, 0, 2, 0, 1};
    vecs[7]  = '{"pause",          1, 0, 6, 0, 0};
    vecs[8]  = '{"resume",         1, 0, 6, 0, 1};
    vecs[9]  = '{"pause2",         1, 0, 6, 0, 0};
    vecs[10] = '{"clear",          0, 1, 6, 1, 0};
    vecs[11] = '{"both_cleared",   1, 1, 6, 0, 1};
    vecs[12] = '{"both_running",   1, 1, 6, 0, 0};
    vecs[13] = '{"both_paused",    1, 1, 6, 1, 0};
    vecs[14] = '{"min_press_run",  1, 0, DB, 0, 1};
    vecs[15] = '{"min_press_pause",1, 0, DB, 0, 0};
    vecs[16] = '{"clear_again",    0, 1, 6, 1, 0};

    reset = 1; btn_start_stop = 0; btn_clear = 0; btn_lap = 0;
    time_reading = 8'h42;
    tick(3);
    expect_now("reset", 1, 0);

    // Latency: the FSM must move on exactly edge DB+3 after raw goes high.
    reset = 0; btn_start_stop = 1;
    for (int e = 1; e <= DB + 3; e++) begin
      tick(1);
      push_exp($sformatf("latency_edge%0d", e), (e < DB + 3), (e >= DB + 3), time_reading);
      check_sb();
    end
    tick(20 - (DB + 3));
    btn_start_stop = 0;
    tick(12);
    expect_now("held20_one_transition", 0, 1);
    press(1, 0, 0, 6);
    expect_now("pause_after_latency", 0, 0);
    press(0, 1, 0, 6);
    expect_now("clear_after_latency", 1, 0);

    for (int i = 0; i < 17; i++) begin
      time_reading = 8'(i);
      push_exp(vecs[i].nm, vecs[i].init, vecs[i].run, time_reading);
      press(vecs[i].s, vecs[i].c, 1'b0, vecs[i].len);
      check_sb();
    end

    // Reset in the middle of a debounce while RUNNING.
    press(1, 0, 0, 6);
    expect_now("run_before_reset", 0, 1);
    btn_start_stop = 1;
    tick(4);
    reset = 1; btn_start_stop = 0;
    tick(1);
    expect_now("reset_mid_debounce", 1, 0);
    reset = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      push_exp($sformatf("no_stale_%0d", k), 1, 0, time_reading);
      check_sb();
    end

    // Button held through reset counts as a fresh press once reset drops.
    btn_start_stop = 1; reset = 1;
    tick(2);
    expect_now("held_in_reset", 1, 0);
    reset = 0;
    for (int e = 1; e <= DB + 3; e++) begin
      tick(1);
      if (e >= DB + 2) begin
        push_exp($sformatf("held_through_reset_edge%0d", e), (e < DB + 3), (e >= DB + 3),
                 time_reading);
        check_sb();
      end
    end
    btn_start_stop = 0;
    tick(10);
    press(1, 0, 0, 6);
    press(0, 1, 0, 6);
    expect_now("back_to_cleared", 1, 0);

`ifdef LAP_HOLD_EN
    press(1, 0, 0, 6);
    time_reading = 8'h23;
    press(0, 0, 1, 6);
    push_exp("lap_hold_23", 0, 1, 8'h23);
    check_sb();
    time_reading = 8'h25;
    #1;
    push_exp("lap_hold_frozen", 0, 1, 8'h23);
    check_sb();
    press(0, 0, 1, 6);
    push_exp("lap_release", 0, 1, 8'h25);
    check_sb();
    press(1, 0, 0, 6);
    press(0, 0, 1, 6);
    time_reading = 8'h31;
    #1;
    push_exp("lap_ignored_paused", 0, 0, 8'h31);
    check_sb();
    press(0, 1, 0, 6);
    expect_now("lap_end_cleared", 1, 0);
`else
    btn_lap = 1;
    for (int k = 0; k < 6; k++) begin
      time_reading = 8'($urandom_range(0, 255));
      tick(1);
      expect_now($sformatf("passthrough_%0d", k), 1, 0);
    end
    btn_lap = 0;
    tick(10);
    expect_now("lap_unused", 1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
